// File: rtl/filter_pkg.sv
// Shared definitions for the packet filter: verdict record layout and gate states.
package filter_pkg;

  localparam int RESULT_WIDTH  = 105;

  localparam int SEND_BIT      = 104;
  localparam int SRC_IP_HI     = 103;
  localparam int SRC_IP_LO     = 72;
  localparam int DST_IP_HI     = 71;
  localparam int DST_IP_LO     = 40;
  localparam int SRC_PORT_HI   = 39;
  localparam int SRC_PORT_LO   = 24;
  localparam int DST_PORT_HI   = 23;
  localparam int DST_PORT_LO   = 8;
  localparam int PROTO_HI      = 7;
  localparam int PROTO_LO      = 0;

  typedef enum logic [1:0] {
    WAIT_VERDICT = 2'b00,
    FORWARD      = 2'b01,
    DROP         = 2'b10
  } gate_state_t;

  function automatic logic verdict_send(input logic [RESULT_WIDTH-1:0] rec);
    return rec[SEND_BIT];
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice: one-cycle latency, full throughput,
// registered upstream ready so no combinational path runs from m_ready to s_ready.
module axis_skid_buffer #(
  parameter int WIDTH = 417
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] out_data_p0, skid_data_p0;
  logic             out_vld_p0, skid_vld_p0, rdy_p0;

  logic [WIDTH-1:0] out_data_nxt, skid_data_nxt;
  logic             out_vld_nxt, skid_vld_nxt;
  logic             in_acc, out_free;

  assign in_acc   = s_valid & rdy_p0;
  assign out_free = ~out_vld_p0 | m_ready;

  // rdy_p0 mirrors an empty skid entry, so in_acc never coincides with a
  // pending skid beat and the skid entry always drains before new input.
  always_comb begin
    out_data_nxt  = out_data_p0;
    out_vld_nxt   = out_vld_p0;
    skid_data_nxt = skid_data_p0;
    skid_vld_nxt  = skid_vld_p0;
    if (out_free) begin
      if (skid_vld_p0) begin
        out_data_nxt = skid_data_p0;
        out_vld_nxt  = 1'b1;
        skid_vld_nxt = 1'b0;
      end else if (in_acc) begin
        out_data_nxt = s_data;
        out_vld_nxt  = 1'b1;
      end else begin
        out_vld_nxt  = 1'b0;
      end
    end else if (in_acc) begin
      skid_data_nxt = s_data;
      skid_vld_nxt  = 1'b1;
    end
  end

  // ---- stage p0: output and skid registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_p0  <= '0;
      out_vld_p0   <= 1'b0;
      skid_data_p0 <= '0;
      skid_vld_p0  <= 1'b0;
      rdy_p0       <= 1'b0;
    end else begin
      out_data_p0  <= out_data_nxt;
      out_vld_p0   <= out_vld_nxt;
      skid_data_p0 <= skid_data_nxt;
      skid_vld_p0  <= skid_vld_nxt;
      rdy_p0       <= ~skid_vld_nxt;
    end
  end

  assign s_ready = rdy_p0;
  assign m_data  = out_data_p0;
  assign m_valid = out_vld_p0;

endmodule

// File: rtl/verdict_gate.sv
// Pops one verdict per packet and forwards or discards the matching packet,
// counting forwarded and dropped packets for the register block.
module verdict_gate
  import filter_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int RESULT_WIDTH         = 105
) (
  input  logic                              axi_aclk,
  input  logic                              axi_areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic [RESULT_WIDTH-1:0]           result_dout,
  input  logic                              result_empty,
  output logic                              result_rd_en,
  input  logic                              counters_clear,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     fwd_pkt_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     drop_pkt_count
);

  localparam int PAYLOAD_W = 1 + C_S_AXIS_TUSER_WIDTH + C_S_AXIS_DATA_WIDTH/8 + C_S_AXIS_DATA_WIDTH;

  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] count_next(
    input logic [C_S_AXI_DATA_WIDTH-1:0] cnt,
    input logic                          clr,
    input logic                          inc
  );
    if (clr) return '0;
    return inc ? cnt + 1'b1 : cnt;
  endfunction

  gate_state_t          state_q, state_nxt;
  logic                 skid_in_valid, skid_ready;
  logic                 fwd_inc, drop_inc;
  logic [PAYLOAD_W-1:0] skid_in, skid_out;

  // Only the send flag steers the gate; the flow tuple is carried for debug taps upstream.
  logic unused_fields;
  assign unused_fields = ^result_dout[SEND_BIT-1:0];

  assign skid_in = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};

  always_comb begin
    state_nxt     = state_q;
    result_rd_en  = 1'b0;
    s_axis_tready = 1'b0;
    skid_in_valid = 1'b0;
    fwd_inc       = 1'b0;
    drop_inc      = 1'b0;
    unique case (state_q)
      WAIT_VERDICT: begin
        if (!result_empty) begin
          result_rd_en = 1'b1;
          state_nxt    = verdict_send(result_dout) ? FORWARD : DROP;
        end
      end
      FORWARD: begin
        s_axis_tready = skid_ready;
        skid_in_valid = s_axis_tvalid;
        if (s_axis_tvalid && skid_ready && s_axis_tlast) begin
          fwd_inc   = 1'b1;
          state_nxt = WAIT_VERDICT;
        end
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          drop_inc  = 1'b1;
          state_nxt = WAIT_VERDICT;
        end
      end
      default: state_nxt = WAIT_VERDICT;
    endcase
    // Handshakes stay quiet while reset is held, whatever the state register holds.
    if (axi_areset) begin
      result_rd_en  = 1'b0;
      s_axis_tready = 1'b0;
      skid_in_valid = 1'b0;
      fwd_inc       = 1'b0;
      drop_inc      = 1'b0;
    end
  end

  // ---- state and counter registers ----
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q        <= WAIT_VERDICT;
      fwd_pkt_count  <= '0;
      drop_pkt_count <= '0;
    end else begin
      state_q        <= state_nxt;
      fwd_pkt_count  <= count_next(fwd_pkt_count, counters_clear, fwd_inc);
      drop_pkt_count <= count_next(drop_pkt_count, counters_clear, drop_inc);
    end
  end

  axis_skid_buffer #(
    .WIDTH (PAYLOAD_W)
  ) u_out_slice (
    .clk     (axi_aclk),
    .rst     (axi_areset),
    .s_data  (skid_in),
    .s_valid (skid_in_valid),
    .s_ready (skid_ready),
    .m_data  (skid_out),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = skid_out;

endmodule

// File: tb/tb_verdict_gate.sv
// Directed bench for verdict_gate: FWFT verdict FIFO and packet source modelled
// by queues, forwarded beats collected and matched against a reference queue.
module tb_verdict_gate;
  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int UW = 128;
  localparam int RW = 105;
  localparam int BW = 1 + UW + SW + DW;
  typedef logic [BW-1:0] beat_t;

  logic          axi_aclk, axi_areset;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic [SW-1:0] s_axis_tstrb, m_axis_tstrb;
  logic [UW-1:0] s_axis_tuser, m_axis_tuser;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [RW-1:0] result_dout;
  logic          result_empty, result_rd_en, counters_clear;
  logic [31:0]   fwd_pkt_count, drop_pkt_count;

  verdict_gate dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .result_dout(result_dout), .result_empty(result_empty), .result_rd_en(result_rd_en),
    .counters_clear(counters_clear), .fwd_pkt_count(fwd_pkt_count), .drop_pkt_count(drop_pkt_count)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  beat_t         txq[$], expq[$], rxq[$];
  logic [RW-1:0] vq[$];
  int  n_cmp = 0, n_bad = 0;
  int  npops = 0, n_s_acc = 0, n_mvalid = 0, n_unstable = 0, n_rdy_hi = 0;
  int  exp_fwd = 0, exp_drop = 0;
  bit  src_en = 1'b1, hold_empty = 1'b0, last_stall = 1'b0;
  beat_t last_m = '0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    s_axis_tvalid = src_en && (txq.size() > 0);
    if (txq.size() > 0) {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata} = txq[0];
    else {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata} = '0;
    result_empty = hold_empty || (vq.size() == 0);
    result_dout  = (vq.size() > 0) ? vq[0] : '0;
  endtask

  task automatic tick();
    bit s_acc, pop;
    beat_t cur_m;
    @(negedge axi_aclk);
    s_acc = s_axis_tvalid && s_axis_tready;
    pop   = result_rd_en;
    cur_m = {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata};
    if (last_stall && m_axis_tvalid && (cur_m !== last_m)) n_unstable++;
    last_stall = m_axis_tvalid && !m_axis_tready;
    last_m     = cur_m;
    if (m_axis_tvalid && m_axis_tready) rxq.push_back(cur_m);
    if (m_axis_tvalid) n_mvalid++;
    if (s_axis_tready) n_rdy_hi++;
    if (pop) npops++;
    if (s_acc) n_s_acc++;
    @(posedge axi_aclk);
    #1;
    if (s_acc) void'(txq.pop_front());
    if (pop && vq.size() > 0) void'(vq.pop_front());
    drive();
    #1;
  endtask

  task automatic add_pkt(input int n, input bit send, input int id);
    beat_t b;
    vq.push_back({send, 104'(id)});
    for (int i = 0; i < n; i++) begin
      b = '0;
      b[DW-1:0]       = {8{32'(id * 256 + i)}};
      b[DW+SW-1:DW]   = 32'hFFFF_FFFF ^ 32'(i * 3);
      b[BW-2:DW+SW]   = {4{32'(id ^ (i << 16))}};
      b[BW-1]         = (i == n - 1);
      txq.push_back(b);
      if (send) expq.push_back(b);
    end
    drive();
  endtask

  task automatic drain(input string tag, input int maxc);
    int c = 0;
    while ((txq.size() > 0 || vq.size() > 0) && c < maxc) begin
      tick();
      c++;
    end
    if (c >= maxc) check({tag, "_timeout"}, txq.size() + vq.size(), 0);
    repeat (4) tick();
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_nbeats"}, rxq.size(), expq.size());
    for (int i = 0; i < rxq.size() && i < expq.size(); i++) check({tag, "_beat"}, rxq[i], expq[i]);
    rxq.delete();
    expq.delete();
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_fwd"}, fwd_pkt_count, exp_fwd);
    check({tag, "_drop"}, drop_pkt_count, exp_drop);
  endtask

  initial begin
    int b_s, b_m, b_p, b_r;
    axi_areset = 1'b1; m_axis_tready = 1'b1; counters_clear = 1'b0;
    drive();
    add_pkt(1, 1'b1, 1);
    repeat (3) tick();
    // reset state, with a verdict already waiting
    check("rst_rd_en", result_rd_en, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_data", {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata}, 0);
    check_counts("rst");

    // one-beat forward
    axi_areset = 1'b0;
    #1;
    check("t1_pop", result_rd_en, 1);
    check("t1_tready_wait", s_axis_tready, 0);
    tick();
    check("t1_pop_once", result_rd_en, 0);
    check("t1_tready_fwd", s_axis_tready, 1);
    tick();
    check("t1_m_tvalid", m_axis_tvalid, 1);
    check("t1_m_data", {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata}, expq[0]);
    exp_fwd = 1;
    check_counts("t1");
    repeat (3) tick();
    check("t1_npops", npops, 1);
    compare_rx("t1");

    // four-beat drop
    b_s = n_s_acc; b_m = n_mvalid; b_r = n_rdy_hi;
    add_pkt(4, 1'b0, 2);
    drain("t2", 20);
    check("t2_m_tvalid_cycles", n_mvalid - b_m, 0);
    check("t2_accepts", n_s_acc - b_s, 4);
    check("t2_tready_cycles", n_rdy_hi - b_r, 4);
    exp_drop = 1;
    check_counts("t2");

    // verdicts 1,0,1 back to back
    b_p = npops;
    add_pkt(3, 1'b1, 3);
    add_pkt(3, 1'b0, 4);
    add_pkt(3, 1'b1, 5);
    drain("t3", 60);
    compare_rx("t3");
    check("t3_pops", npops - b_p, 3);
    exp_fwd = 3; exp_drop = 2;
    check_counts("t3");

    // eight beats with toggling downstream ready
    add_pkt(8, 1'b1, 6);
    for (int c = 0; c < 80 && (txq.size() > 0 || vq.size() > 0); c++) begin
      m_axis_tready = (c % 2 == 0);
      drive();
      tick();
    end
    m_axis_tready = 1'b1;
    repeat (4) tick();
    compare_rx("t4");
    check("t4_unstable", n_unstable, 0);
    exp_fwd = 4;
    check_counts("t4");

    // verdict FIFO empty while data waits
    hold_empty = 1'b1;
    add_pkt(2, 1'b1, 7);
    b_r = n_rdy_hi; b_p = npops; b_s = n_s_acc;
    repeat (10) tick();
    check("t5_tready_stalled", n_rdy_hi - b_r, 0);
    check("t5_pops_stalled", npops - b_p, 0);
    check("t5_accepts_stalled", n_s_acc - b_s, 0);
    hold_empty = 1'b0;
    drive();
    #1;
    check("t5_pop", result_rd_en, 1);
    tick();
    check("t5_tready_after", s_axis_tready, 1);
    drain("t5", 20);
    compare_rx("t5");
    exp_fwd = 5;
    check_counts("t5");

    // verdict with no packet data yet
    src_en = 1'b0;
    b_p = npops; b_s = n_s_acc;
    add_pkt(1, 1'b0, 8);
    repeat (5) tick();
    check("t5b_pops", npops - b_p, 1);
    check("t5b_accepts", n_s_acc - b_s, 0);
    check("t5b_tready_drop", s_axis_tready, 1);
    src_en = 1'b1;
    drive();
    drain("t5b", 20);
    exp_drop = 3;
    check_counts("t5b");

    // counter wrap
    force dut.fwd_pkt_count = 32'hFFFF_FFFF;
    #1;
    release dut.fwd_pkt_count;
    check("t6_preload", fwd_pkt_count, 32'hFFFF_FFFF);
    add_pkt(1, 1'b1, 9);
    drain("t6", 20);
    compare_rx("t6");
    exp_fwd = 0;
    check_counts("t6");

    // clear coincident with a counted tlast
    exp_fwd = 2;
    add_pkt(1, 1'b1, 15);
    add_pkt(1, 1'b1, 16);
    drain("t6c", 20);
    check_counts("t6c_pre");
    add_pkt(2, 1'b1, 10);
    tick();
    tick();
    counters_clear = 1'b1;
    tick();
    counters_clear = 1'b0;
    exp_fwd = 0; exp_drop = 0;
    check_counts("t6c");
    repeat (3) tick();
    compare_rx("t6c");
    add_pkt(1, 1'b0, 11);
    drain("t6d", 20);
    exp_drop = 1;
    check_counts("t6d");

    // held backpressure
    m_axis_tready = 1'b0;
    add_pkt(6, 1'b1, 12);
    b_s = n_s_acc;
    repeat (12) tick();
    check("t7_accepts_stalled", n_s_acc - b_s, 2);
    check("t7_m_tvalid", m_axis_tvalid, 1);
    check("t7_m_data", {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata}, expq[0]);
    check("t7_tready", s_axis_tready, 0);
    m_axis_tready = 1'b1;
    drive();
    drain("t7", 40);
    compare_rx("t7");
    exp_fwd = 1;
    check_counts("t7");

    // reset on beat 2 of a five-beat forwarded packet
    add_pkt(5, 1'b1, 13);
    tick();
    tick();
    tick();
    axi_areset = 1'b1;
    #1;
    tick();
    check("t8_m_tvalid", m_axis_tvalid, 0);
    check("t8_state", dut.state_q, 0);
    check("t8_tready", s_axis_tready, 0);
    exp_fwd = 0; exp_drop = 0;
    check_counts("t8");
    axi_areset = 1'b0;
    txq.delete(); vq.delete(); rxq.delete(); expq.delete();
    drive();
    add_pkt(1, 1'b1, 14);
    drain("t8b", 20);
    compare_rx("t8b");
    exp_fwd = 1;
    check_counts("t8b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
